alu_sequencer: RTL and testbench

- Multi-cycle control and datapath front end that drives the existing combinational `alu` block.
- Accepts an 8-bit instruction word on a Run strobe and holds a four-entry 8-bit register file (R0..R3).
- Sequences each instruction through operand load (register A), ALU evaluation with capture into register G, and write-back, all over a shared BusWires.
- Sits between instruction issue and the `alu`: it is the initiator whose outputs are the `alu`'s Inst, A and BusWires inputs.

---
 rtl/alu_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of the combinational alu: latches an instruction,
// loads operand A, captures the alu result into G and writes it back over BusWires.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for Run; IR latched on the accepting edge
// S_T1   | ALU op: R[Rx] -> A; MV/MVI: write Rx; illegal: flag only
// S_T2   | alu evaluates A op R[Ry]; result captured in G
// S_T3   | G written back to R[Rx]
// S_DONE | Done (and IllegalOp if flagged) for one cycle
module alu_sequencer #(
  parameter logic [3:0] IDLE_INST = 4'b1111
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [7:0] IR,
  input  logic [7:0] Din,
  input  logic [7:0] AluResult,
  output logic [3:0] AluInst,
  output logic [7:0] AluA,
  output logic [7:0] BusWires,
  output logic       Busy,
  output logic       Done,
  output logic       IllegalOp,
  input  logic [1:0] DbgSel,
  output logic [7:0] DbgData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] ir_q;
  logic [7:0] a_q;
  logic [7:0] g_q;
  logic [7:0] regs [4];

  logic [3:0] op;
  logic [1:0] rx;
  logic [1:0] ry;
  logic       is_mv;
  logic       is_mvi;
  logic       is_ill;

  assign op     = ir_q[7:4];
  assign rx     = ir_q[3:2];
  assign ry     = ir_q[1:0];
  assign is_mv  = (op == 4'b0001);
  assign is_mvi = (op == 4'b1000);
  assign is_ill = (op == 4'b1001) || (op == 4'b1111);

  assign AluA    = a_q;
  assign DbgData = regs[DbgSel];

  // Bus is combinational so MVI can pass Din straight through in T1.
  always_comb begin
    BusWires = '0;
    case (state)
      S_T1: begin
        if (is_mv)       BusWires = regs[ry];
        else if (is_mvi) BusWires = Din;
        else if (!is_ill) BusWires = regs[rx];
      end
      S_T2:    BusWires = regs[ry];
      S_T3:    BusWires = g_q;
      default: BusWires = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      ir_q      <= '0;
      a_q       <= '0;
      g_q       <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      AluInst   <= IDLE_INST;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      Done      <= 1'b0;
      IllegalOp <= 1'b0;
      AluInst   <= IDLE_INST;
      case (state)
        S_IDLE: begin
          if (Run) begin
            ir_q  <= IR;
            state <= S_T1;
            Busy  <= 1'b1;
          end
        end
        S_T1: begin
          if (is_mv || is_mvi) begin
            regs[rx] <= BusWires;
            state    <= S_DONE;
            Done     <= 1'b1;
          end else if (is_ill) begin
            state     <= S_DONE;
            Done      <= 1'b1;
            IllegalOp <= 1'b1;
          end else begin
            a_q     <= BusWires;
            state   <= S_T2;
            AluInst <= op;
          end
        end
        S_T2: begin
          g_q   <= AluResult;
          state <= S_T3;
        end
        S_T3: begin
          regs[rx] <= g_q;
          state    <= S_DONE;
          Done     <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, abort/back-to-back
// sequences, and random instructions against a register-file reference model.
module tb_alu_sequencer;

  localparam logic [3:0] IDLE_INST = 4'b1111;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [7:0] IR;
  logic [7:0] Din;
  logic [7:0] AluResult;
  logic [3:0] AluInst;
  logic [7:0] AluA;
  logic [7:0] BusWires;
  logic       Busy;
  logic       Done;
  logic       IllegalOp;
  logic [1:0] DbgSel;
  logic [7:0] DbgData;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] m [4];

  alu_sequencer #(.IDLE_INST(IDLE_INST)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .Din(Din),
    .AluResult(AluResult), .AluInst(AluInst), .AluA(AluA), .BusWires(BusWires),
    .Busy(Busy), .Done(Done), .IllegalOp(IllegalOp), .DbgSel(DbgSel), .DbgData(DbgData)
  );

  always #5 Clock = ~Clock;

  // Behaviour of the external alu; unary ops act on A only.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0:    return p[7:0];
      4'h2:    return a + b;
      4'h3:    return a - b;
      4'h4:    return a & b;
      4'h5:    return ~(a & b);
      4'h6:    return a | b;
      4'h7:    return ~(a | b);
      4'hA:    return (a >> 1) | (a << 7);
      4'hB:    return (a << 1) | (a >> 7);
      4'hC:    return ~a;
      4'hD:    return a << 1;
      4'hE:    return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  assign AluResult = alu_fn(AluInst, AluA, BusWires);

  function automatic bit is_illegal(input logic [3:0] op);
    return (op == 4'h9) || (op == 4'hF);
  endfunction

  function automatic bit is_alu(input logic [3:0] op);
    return !(op == 4'h1 || op == 4'h8 || is_illegal(op));
  endfunction

  task automatic ref_exec(input logic [7:0] ir, input logic [7:0] din);
    logic [3:0] op;
    logic [1:0] rx, ry;
    op = ir[7:4]; rx = ir[3:2]; ry = ir[1:0];
    if (op == 4'h1)          m[rx] = m[ry];
    else if (op == 4'h8)     m[rx] = din;
    else if (is_alu(op))     m[rx] = alu_fn(op, m[rx], m[ry]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic read_reg(input int i, output logic [7:0] v);
    DbgSel = 2'(i);
    #1;
    v = DbgData;
  endtask

  task automatic chk_regs(input string name);
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      chk($sformatf("%s R%0d", name, i), v, m[i]);
    end
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (Done !== 1'b1 && n <= 8) begin
      @(posedge Clock); #1;
      n++;
    end
  endtask

  // Issue one instruction from IDLE, check every cycle until Done, then the model.
  task automatic do_inst(input logic [7:0] ir, input logic [7:0] din, input string name,
                         output int lat, output bit ill);
    logic [3:0] op;
    logic [1:0] rx, ry;
    logic [7:0] exp_g;
    logic [3:0] exp_inst;
    int exp_lat, bad;
    bit seen;
    op = ir[7:4]; rx = ir[3:2]; ry = ir[1:0];
    exp_lat = is_alu(op) ? 4 : 2;
    exp_g   = alu_fn(op, m[rx], m[ry]);
    IR = ir; Din = din; Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0;
    IR  = 8'($urandom);
    lat = 1; bad = 0; seen = 0; ill = 0;
    while (!seen && lat <= 8) begin
      if (Busy !== 1'b1) bad++;
      exp_inst = (is_alu(op) && lat == 2) ? op : IDLE_INST;
      if (AluInst !== exp_inst) bad++;
      if (IllegalOp !== ((Done === 1'b1) && is_illegal(op))) bad++;
      if (lat == 1) begin
        if (op == 4'h1 && BusWires !== m[ry]) bad++;
        if (op == 4'h8 && BusWires !== din) bad++;
        if (is_alu(op) && BusWires !== m[rx]) bad++;
      end
      if (is_alu(op) && lat == 2 && (BusWires !== m[ry] || AluA !== m[rx])) bad++;
      if (is_alu(op) && lat == 3 && BusWires !== exp_g) bad++;
      if (Done === 1'b1) begin
        seen = 1;
        ill  = (IllegalOp === 1'b1);
      end else begin
        @(posedge Clock); #1;
        lat++;
      end
    end
    chk({name, " done seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " cycle signals"}, bad, 0);
    @(posedge Clock); #1;
    chk({name, " idle after"}, {Busy, Done, IllegalOp, BusWires, AluInst},
        {1'b0, 1'b0, 1'b0, 8'h00, IDLE_INST});
    ref_exec(ir, din);
    chk_regs(name);
  endtask

  typedef struct {
    logic [7:0] ir;
    logic [7:0] din;
    logic [7:0] exp_dst;
    int         exp_lat;
    bit         exp_ill;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int lat, n;
    bit ill;
    logic [7:0] v;
    int done_cnt;

    vecs[0]  = '{8'h80, 8'h04, 8'h04, 2, 1'b0};  // MVI R0,#04
    vecs[1]  = '{8'h84, 8'h02, 8'h02, 2, 1'b0};  // MVI R1,#02
    vecs[2]  = '{8'h01, 8'h00, 8'h08, 4, 1'b0};  // MUL R0,R1
    vecs[3]  = '{8'h88, 8'hFF, 8'hFF, 2, 1'b0};  // MVI R2,#FF
    vecs[4]  = '{8'h8C, 8'h01, 8'h01, 2, 1'b0};  // MVI R3,#01
    vecs[5]  = '{8'h2B, 8'h00, 8'h00, 4, 1'b0};  // ADD R2,R3 wraps
    vecs[6]  = '{8'h3E, 8'h00, 8'h01, 4, 1'b0};  // SUB R3,R2
    vecs[7]  = '{8'h88, 8'h1C, 8'h1C, 2, 1'b0};
    vecs[8]  = '{8'h8C, 8'h0C, 8'h0C, 2, 1'b0};
    vecs[9]  = '{8'h3B, 8'h00, 8'h10, 4, 1'b0};  // SUB R2,R3
    vecs[10] = '{8'h84, 8'h01, 8'h01, 2, 1'b0};
    vecs[11] = '{8'hA4, 8'h00, 8'h80, 4, 1'b0};  // ROR R1
    vecs[12] = '{8'hB4, 8'h00, 8'h01, 4, 1'b0};  // ROL R1
    vecs[13] = '{8'hE4, 8'h00, 8'h00, 4, 1'b0};  // SHR R1
    vecs[14] = '{8'h84, 8'h1E, 8'h1E, 2, 1'b0};
    vecs[15] = '{8'hD4, 8'h00, 8'h3C, 4, 1'b0};  // SHL R1
    vecs[16] = '{8'hC4, 8'h00, 8'hC3, 4, 1'b0};  // NOT R1
    vecs[17] = '{8'h94, 8'h55, 8'hC3, 2, 1'b1};  // illegal 1001
    vecs[18] = '{8'hF4, 8'h55, 8'hC3, 2, 1'b1};  // illegal 1111
    vecs[19] = '{8'h11, 8'h00, 8'hC3, 2, 1'b0};  // MV R0,R1
    vecs[20] = '{8'h25, 8'h00, 8'h86, 4, 1'b0};  // ADD R1,R1 doubles

    Run = 1'b0; IR = 8'h00; Din = 8'h00; DbgSel = 2'd0; Resetn = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset outputs", {Busy, Done, IllegalOp, BusWires, AluInst, AluA},
        {1'b0, 1'b0, 1'b0, 8'h00, IDLE_INST, 8'h00});
    chk_regs("reset");
    Resetn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      do_inst(vecs[i].ir, vecs[i].din, $sformatf("vec%0d", i), lat, ill);
      chk($sformatf("vec%0d table latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d illegal", i), 32'(ill), 32'(vecs[i].exp_ill));
      read_reg(int'(vecs[i].ir[3:2]), v);
      chk($sformatf("vec%0d dest", i), v, vecs[i].exp_dst);
    end

    // Reset during T2 of ADD R0,R1 aborts without write-back or Done.
    do_inst(8'h80, 8'h11, "abort setup R0", lat, ill);
    do_inst(8'h84, 8'h01, "abort setup R1", lat, ill);
    IR = 8'h21; Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(posedge Clock); #1;
    chk("abort in T2 alu_inst", AluInst, 4'h2);
    Resetn = 1'b0;
    @(posedge Clock); #1;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    chk("abort outputs", {Busy, Done, IllegalOp, BusWires, AluInst},
        {1'b0, 1'b0, 1'b0, 8'h00, IDLE_INST});
    Resetn = 1'b1;
    done_cnt = 0;
    repeat (6) begin
      @(posedge Clock); #1;
      if (Done === 1'b1 || Busy === 1'b1) done_cnt++;
    end
    chk("abort no done", done_cnt, 0);
    chk_regs("abort");

    // Run held high: NAND then NOR with one IDLE gap; IR noise while busy ignored.
    do_inst(8'h80, 8'h3D, "b2b setup R0", lat, ill);
    do_inst(8'h84, 8'h01, "b2b setup R1", lat, ill);
    IR = 8'h51; Run = 1'b1;
    @(posedge Clock); #1;
    IR = 8'h8D;
    wait_done(n);
    chk("b2b nand latency", n, 4);
    read_reg(0, v);
    chk("b2b nand R0", v, 8'hFE);
    ref_exec(8'h51, 8'h00);
    IR = 8'h71;
    @(posedge Clock); #1;
    chk("b2b idle gap", {Busy, Done}, 2'b00);
    @(posedge Clock); #1;
    chk("b2b second start", Busy, 1'b1);
    Run = 1'b0; IR = 8'hFF;
    wait_done(n);
    chk("b2b nor latency", n, 4);
    @(posedge Clock); #1;
    ref_exec(8'h71, 8'h00);
    read_reg(0, v);
    chk("b2b nor R0", v, 8'h00);
    chk_regs("b2b");

    for (int i = 0; i < 150; i++)
      do_inst(8'($urandom), 8'($urandom), $sformatf("rnd%0d", i), lat, ill);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
